// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
// Shared definitions for the RTC multiplexed-bus sequencer:
//   - FSM state encoding for the bus transaction sequence
//   - idle levels of the RTC pins
//   - per-state pin pattern (pins_t) and the helper that produces it
//   - RTC register addresses, shared with the user-control block
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ADDR_SETUP  = 3'd1,
        ST_ADDR_STROBE = 3'd2,
        ST_ADDR_HOLD   = 3'd3,
        ST_DATA_SETUP  = 3'd4,
        ST_DATA_STROBE = 3'd5,
        ST_DATA_HOLD   = 3'd6,
        ST_DONE        = 3'd7
    } state_t;

    // Pin levels while no transaction is running
    localparam logic PIN_CS_IDLE = 1'b1;
    localparam logic PIN_AD_IDLE = 1'b1;
    localparam logic PIN_RD_IDLE = 1'b1;
    localparam logic PIN_WR_IDLE = 1'b1;
    localparam logic PIN_OE_IDLE = 1'b0;

    // RTC register addresses
    localparam logic [7:0] RTC_ADDR_80 = 8'h80;
    localparam logic [7:0] RTC_ADDR_32 = 8'h32;
    localparam logic [7:0] RTC_ADDR_33 = 8'h33;
    localparam logic [7:0] RTC_ADDR_34 = 8'h34;
    localparam logic [7:0] RTC_ADDR_35 = 8'h35;
    localparam logic [7:0] RTC_ADDR_36 = 8'h36;
    localparam logic [7:0] RTC_ADDR_38 = 8'h38;
    localparam logic [7:0] RTC_ADDR_49 = 8'h49;
    localparam logic [7:0] RTC_ADDR_50 = 8'h50;
    localparam logic [7:0] RTC_ADDR_51 = 8'h51;
    localparam logic [7:0] RTC_ADDR_52 = 8'h52;
    localparam logic [7:0] RTC_ADDR_65 = 8'h65;
    localparam logic [7:0] RTC_ADDR_67 = 8'h67;

    // Pin pattern for one state; sel_addr/sel_data choose what ad_out drives
    typedef struct packed {
        logic cs_n;
        logic ad_n;
        logic rd_n;
        logic wr_n;
        logic oe;
        logic sel_addr;
        logic sel_data;
        logic fin;
    } pins_t;

    // Pin pattern to present while the FSM sits in state s
    function automatic pins_t pins_for(input state_t s, input logic is_read);
        pins_t p;
        p.cs_n     = PIN_CS_IDLE;
        p.ad_n     = PIN_AD_IDLE;
        p.rd_n     = PIN_RD_IDLE;
        p.wr_n     = PIN_WR_IDLE;
        p.oe       = PIN_OE_IDLE;
        p.sel_addr = 1'b0;
        p.sel_data = 1'b0;
        p.fin      = 1'b0;
        case (s)
            ST_IDLE: begin
                p.fin = 1'b0;
            end
            ST_ADDR_SETUP, ST_ADDR_HOLD: begin
                p.cs_n     = 1'b0;
                p.ad_n     = 1'b0;
                p.oe       = 1'b1;
                p.sel_addr = 1'b1;
            end
            ST_ADDR_STROBE: begin
                // The RTC latches the address on WR_n for reads as well
                p.cs_n     = 1'b0;
                p.ad_n     = 1'b0;
                p.wr_n     = 1'b0;
                p.oe       = 1'b1;
                p.sel_addr = 1'b1;
            end
            ST_DATA_SETUP, ST_DATA_HOLD: begin
                p.cs_n     = 1'b0;
                p.oe       = ~is_read;
                p.sel_data = ~is_read;
            end
            ST_DATA_STROBE: begin
                p.cs_n     = 1'b0;
                p.oe       = ~is_read;
                p.sel_data = ~is_read;
                p.rd_n     = ~is_read;
                p.wr_n     = is_read;
            end
            ST_DONE: begin
                p.fin = 1'b1;
            end
            default: begin
                p.fin = 1'b0;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// rtc_phase_timer
// Loadable down-counter that times each bus phase. It counts down from the
// loaded value to zero and then holds at zero; done is high at zero.
// Ports:
//   CLK   - system clock
//   reset - synchronous, active-high reset (counter to zero)
//   load  - reload the counter with T_PHASE-1 (asserted on each state entry)
//   done  - counter is at zero: the current phase ends on this clock edge
module rtc_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(T_PHASE) + 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(T_PHASE - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count_r;

    // Phase counter: reload on state entry, otherwise count down and stop at zero
    always_ff @(posedge CLK) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (count_r != '0) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Runs one single-register read or write on the multiplexed 8-bit
// address/data bus of the external RTC: address phase (setup, WR_n strobe,
// hold) then data phase (setup, RD_n or WR_n strobe, hold), then a one-cycle
// DONE with fin. Every phase lasts T_PHASE clocks. All outputs are registered.
// Ports:
//   CLK, reset          - clock and synchronous active-high reset
//   escritura, read     - level requests sampled in IDLE (write has priority)
//   ADD2, Dato_in       - register address / write data, latched at request
//   fin, busy           - completion pulse / transaction in progress
//   Dato_out            - last byte read, kept until the next completed read
//   CS_n, AD_n, RD_n, WR_n - RTC strobes (AD_n: 0 = address, 1 = data)
//   ad_out, ad_oe, ad_in - bus drive value, drive enable, sampled bus value
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       escritura,
    input  logic       read,
    input  logic [7:0] ADD2,
    input  logic [7:0] Dato_in,
    output logic       fin,
    output logic       busy,
    output logic [7:0] Dato_out,
    output logic       CS_n,
    output logic       AD_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    state_t     state_r;
    state_t     nxt_s;
    logic       t_done_s;
    logic       load_s;
    logic       req_s;
    logic       is_read_r;
    logic [7:0] addr_r;
    logic [7:0] data_r;
    logic [7:0] cap_r;
    logic       nxt_read_s;
    logic [7:0] nxt_addr_s;
    logic [7:0] nxt_data_s;
    pins_t      np_s;

    assign req_s = escritura | read;

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
        .CLK   (CLK),
        .reset (reset),
        .load  (load_s),
        .done  (t_done_s)
    );

    // Next-state logic: each bus phase advances when the phase timer expires
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_IDLE:        nxt_s = req_s    ? ST_ADDR_SETUP  : ST_IDLE;
            ST_ADDR_SETUP:  nxt_s = t_done_s ? ST_ADDR_STROBE : ST_ADDR_SETUP;
            ST_ADDR_STROBE: nxt_s = t_done_s ? ST_ADDR_HOLD   : ST_ADDR_STROBE;
            ST_ADDR_HOLD:   nxt_s = t_done_s ? ST_DATA_SETUP  : ST_ADDR_HOLD;
            ST_DATA_SETUP:  nxt_s = t_done_s ? ST_DATA_STROBE : ST_DATA_SETUP;
            ST_DATA_STROBE: nxt_s = t_done_s ? ST_DATA_HOLD   : ST_DATA_STROBE;
            ST_DATA_HOLD:   nxt_s = t_done_s ? ST_DONE        : ST_DATA_HOLD;
            ST_DONE:        nxt_s = ST_IDLE;
            default:        nxt_s = ST_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so pins line up
    // with the state itself; in IDLE the request inputs are used directly
    // because they are latched on this same edge.
    always_comb begin
        load_s     = (nxt_s != state_r);
        nxt_read_s = is_read_r;
        nxt_addr_s = addr_r;
        nxt_data_s = data_r;
        if (state_r == ST_IDLE) begin
            nxt_read_s = read & ~escritura;
            nxt_addr_s = ADD2;
            nxt_data_s = Dato_in;
        end else begin
            nxt_read_s = is_read_r;
        end
        np_s = pins_for(nxt_s, nxt_read_s);
    end

    // Transaction FSM: state, request latches, read capture and pin registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            is_read_r <= 1'b0;
            addr_r    <= 8'h00;
            data_r    <= 8'h00;
            cap_r     <= 8'h00;
            Dato_out  <= 8'h00;
            CS_n      <= PIN_CS_IDLE;
            AD_n      <= PIN_AD_IDLE;
            RD_n      <= PIN_RD_IDLE;
            WR_n      <= PIN_WR_IDLE;
            ad_oe     <= PIN_OE_IDLE;
            ad_out    <= 8'h00;
            fin       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r <= nxt_s;
            if ((state_r == ST_IDLE) && req_s) begin
                is_read_r <= nxt_read_s;
                addr_r    <= ADD2;
                data_r    <= Dato_in;
            end
            // Bus is sampled on the last cycle of the read strobe
            if ((state_r == ST_DATA_STROBE) && t_done_s && is_read_r) begin
                cap_r <= ad_in;
            end
            // Publish the read byte together with fin
            if ((state_r == ST_DATA_HOLD) && t_done_s && is_read_r) begin
                Dato_out <= cap_r;
            end
            CS_n   <= np_s.cs_n;
            AD_n   <= np_s.ad_n;
            RD_n   <= np_s.rd_n;
            WR_n   <= np_s.wr_n;
            ad_oe  <= np_s.oe;
            fin    <= np_s.fin;
            busy   <= (nxt_s != ST_IDLE);
            ad_out <= np_s.sel_addr ? nxt_addr_s :
                      (np_s.sel_data ? nxt_data_s : 8'h00);
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Testbench for rtc_bus_sequencer: one instance with T_PHASE=4 and one with
// T_PHASE=1, a table of single transactions, plus hand-written sequences for
// back-to-back requests and reset during a read strobe.
module tb_rtc_bus_sequencer;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       esc4 = 1'b0, rd4 = 1'b0, esc1 = 1'b0, rd1 = 1'b0;
    logic [7:0] ADD2 = 8'h00, Dato_in = 8'h00, ad_in = 8'h00;

    logic       fin4, busy4, cs4, adn4, rdn4, wrn4, oe4;
    logic [7:0] dout4, ado4;
    logic       fin1, busy1, cs1, adn1, rdn1, wrn1, oe1;
    logic [7:0] dout1, ado1;

    always #5 CLK = ~CLK;

    rtc_bus_sequencer #(.T_PHASE(4)) dut4 (
        .CLK(CLK), .reset(reset), .escritura(esc4), .read(rd4),
        .ADD2(ADD2), .Dato_in(Dato_in), .fin(fin4), .busy(busy4),
        .Dato_out(dout4), .CS_n(cs4), .AD_n(adn4), .RD_n(rdn4), .WR_n(wrn4),
        .ad_out(ado4), .ad_oe(oe4), .ad_in(ad_in)
    );

    rtc_bus_sequencer #(.T_PHASE(1)) dut1 (
        .CLK(CLK), .reset(reset), .escritura(esc1), .read(rd1),
        .ADD2(ADD2), .Dato_in(Dato_in), .fin(fin1), .busy(busy1),
        .Dato_out(dout1), .CS_n(cs1), .AD_n(adn1), .RD_n(rdn1), .WR_n(wrn1),
        .ad_out(ado1), .ad_oe(oe1), .ad_in(ad_in)
    );

    typedef struct {
        int         sel;
        logic       esc;
        logic       rd;
        logic [7:0] add2;
        logic [7:0] din;
        logic [7:0] adin;
        int         fin_cyc;
        int         wr_a;
        int         wr_d;
        int         rd_low;
        int         busy_cyc;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_fail = 0;

    // Per-transaction observations
    int         fin_first, fin_last, fin_cnt, wr_a, wr_d, rdl, busy_c, viol, cs_fall;
    logic       prev_cs;
    logic [7:0] addr_seen, data_seen, dout_at_fin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        fin_first = 0; fin_last = 0; fin_cnt = 0; wr_a = 0; wr_d = 0;
        rdl = 0; busy_c = 0; viol = 0; cs_fall = 0; prev_cs = 1'b1;
        addr_seen = 8'h00; data_seen = 8'h00; dout_at_fin = 8'h00;
    endtask

    task automatic sample(input int sel, input int k);
        logic f, b, cs, an, rn, wn, oe;
        logic [7:0] ao, dq;
        if (sel == 1) begin
            f = fin1; b = busy1; cs = cs1; an = adn1; rn = rdn1; wn = wrn1;
            oe = oe1; ao = ado1; dq = dout1;
        end else begin
            f = fin4; b = busy4; cs = cs4; an = adn4; rn = rdn4; wn = wrn4;
            oe = oe4; ao = ado4; dq = dout4;
        end
        if (f) begin
            fin_cnt++;
            if (fin_first == 0) begin
                fin_first = k;
                dout_at_fin = dq;
            end
            fin_last = k;
        end
        if (prev_cs && !cs) cs_fall = k;
        prev_cs = cs;
        if (!wn && !an) begin wr_a++; addr_seen = ao; end
        if (!wn && an)  begin wr_d++; data_seen = ao; end
        if (!rn) rdl++;
        if (b) busy_c++;
        if ((!rn && !wn) || (oe && !rn)) viol++;
    endtask

    initial begin
        vecs[0] = '{4, 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 25, 4, 4, 0, 25, 8'h21, 8'h45, 8'h00};
        vecs[1] = '{4, 1'b0, 1'b1, 8'h33, 8'h00, 8'h17, 25, 4, 0, 4, 25, 8'h33, 8'h00, 8'h17};
        vecs[2] = '{4, 1'b1, 1'b1, 8'h40, 8'h99, 8'h55, 25, 4, 4, 0, 25, 8'h40, 8'h99, 8'h17};
        vecs[3] = '{4, 1'b0, 1'b1, 8'h80, 8'h00, 8'hA5, 25, 4, 0, 4, 25, 8'h80, 8'h00, 8'hA5};
        vecs[4] = '{4, 1'b1, 1'b0, 8'h36, 8'h00, 8'h3C, 25, 4, 4, 0, 25, 8'h36, 8'h00, 8'hA5};
        vecs[5] = '{1, 1'b1, 1'b0, 8'h52, 8'h3C, 8'h00,  7, 1, 1, 0,  7, 8'h52, 8'h3C, 8'h00};
        vecs[6] = '{1, 1'b0, 1'b1, 8'h41, 8'h00, 8'h6E,  7, 1, 0, 1,  7, 8'h41, 8'h00, 8'h6E};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_pins4", {cs4, adn4, rdn4, wrn4, oe4, fin4, busy4}, 7'b1111000);
        check("reset_ado4", ado4, 8'h00);
        check("reset_dout4", dout4, 8'h00);
        check("reset_pins1", {cs1, adn1, rdn1, wrn1, oe1, fin1, busy1}, 7'b1111000);
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_pins4", {cs4, adn4, rdn4, wrn4, oe4, fin4, busy4}, 7'b1111000);

        // Table of single transactions
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (vecs[i].sel == 1) begin esc1 = vecs[i].esc; rd1 = vecs[i].rd; end
            else                  begin esc4 = vecs[i].esc; rd4 = vecs[i].rd; end
            ADD2 = vecs[i].add2; Dato_in = vecs[i].din; ad_in = vecs[i].adin;
            @(posedge CLK);
            clear_stats();
            for (int k = 1; k <= 30; k++) begin
                @(negedge CLK);
                sample(vecs[i].sel, k);
                if (k == 1) begin
                    esc4 = 1'b0; rd4 = 1'b0; esc1 = 1'b0; rd1 = 1'b0;
                    ADD2 = 8'hFF; Dato_in = 8'hEE;
                end
            end
            check($sformatf("v%0d_fin_cycle", i), fin_first, vecs[i].fin_cyc);
            check($sformatf("v%0d_fin_count", i), fin_cnt, 1);
            check($sformatf("v%0d_wr_addr_low", i), wr_a, vecs[i].wr_a);
            check($sformatf("v%0d_wr_data_low", i), wr_d, vecs[i].wr_d);
            check($sformatf("v%0d_rd_low", i), rdl, vecs[i].rd_low);
            check($sformatf("v%0d_busy_cycles", i), busy_c, vecs[i].busy_cyc);
            check($sformatf("v%0d_addr", i), addr_seen, vecs[i].exp_addr);
            check($sformatf("v%0d_data", i), data_seen, vecs[i].exp_data);
            check($sformatf("v%0d_dout_at_fin", i), dout_at_fin, vecs[i].exp_dout);
            check($sformatf("v%0d_strobe_overlap", i), viol, 0);
        end

        // Back-to-back writes: escritura held high across fin
        @(negedge CLK);
        esc4 = 1'b1; ADD2 = 8'h32; Dato_in = 8'h11;
        @(posedge CLK);
        clear_stats();
        for (int k = 1; k <= 80; k++) begin
            @(negedge CLK);
            sample(4, k);
            if (k == 52) esc4 = 1'b0;
        end
        check("b2b_fin_count", fin_cnt, 2);
        check("b2b_fin_first", fin_first, 25);
        check("b2b_fin_second", fin_last, 51);
        check("b2b_cs_fall_second", cs_fall, 27);
        check("b2b_wr_addr_low", wr_a, 8);
        check("b2b_wr_data_low", wr_d, 8);
        check("b2b_dout_kept", dout4, 8'hA5);

        // Reset during the data strobe of a read
        @(negedge CLK);
        rd4 = 1'b1; ADD2 = 8'h34; ad_in = 8'h5A;
        @(posedge CLK);
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            if (k == 1) rd4 = 1'b0;
        end
        check("rst_pre_rd_low", rdn4, 1'b0);
        reset = 1'b1;
        @(negedge CLK);
        check("rst_mid_pins", {cs4, adn4, rdn4, wrn4, oe4, fin4, busy4}, 7'b1111000);
        check("rst_mid_dout", dout4, 8'h00);
        reset = 1'b0;
        clear_stats();
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLK);
            sample(4, k);
        end
        check("rst_no_fin", fin_cnt, 0);
        check("rst_no_busy", busy_c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
